im_load_ctrl: RTL and testbench
===============================

// Module: im_load_ctrl
// PURPOSE
//  Sequences and arbitrates the 16-word register-based instruction memory (IM) port between the CPU
//  fetch path and a boot/debug loader stream. In IDLE, fetch passes straight through to the IM.
//  A load burst stalls fetch and writes ld_count words from ld_base upward, wrapping within the IM.
//  Sits between the PC/fetch stage, the loader source and the IM (pc, dataIn, memWrite, memRead).
// PARAMETERS
//  DEPTH   16  IM words; load bursts are 1..DEPTH words
//  ADDR_W  4   word-address width (log2 DEPTH); the IM decodes pc[ADDR_W+1:2]
//  DATA_W  32  instruction width
// PORTS
//  clk          in   1       system clock; all state changes on posedge
//  reset        in   1       asynchronous, active-low reset
//  fetch_req    in   1       CPU requests an instruction read this cycle
//  fetch_pc     in   32      CPU fetch byte address
//  fetch_stall  out  1       1 = fetch not served this cycle, CPU must hold PC
//  ld_start     in   1       start a load burst (sampled in IDLE only)
//  ld_base      in   ADDR_W  first word address of the burst
//  ld_count     in   ADDR_W+1  number of words, legal 1..DEPTH
//  ld_valid     in   1       loader word valid
//  ld_data      in   DATA_W  loader word
//  ld_ready     out  1       controller accepts ld_data when ld_valid&&ld_ready
//  ld_done      out  1       one-cycle pulse: last word committed
//  ld_err       out  1       one-cycle pulse: ld_start with illegal ld_count
//  busy         out  1       1 in LOAD or LAST
//  im_pc        out  32      IM address
//  im_dataIn    out  DATA_W  IM write data
//  im_memWrite  out  1       IM write enable
//  im_memRead   out  1       IM read enable
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; ld_ready, ld_done, ld_err, busy, fetch_stall, im_memWrite=0;
//   im_dataIn=0; internal word counter/address=0. Mid-burst reset aborts immediately; words already
//   written stay written (no rollback); im_memWrite drops asynchronously.
//  FSM: IDLE -> LOAD on ld_start with 1<=ld_count<=DEPTH (base/count latched). LOAD -> LAST when the
//   final word is accepted. LAST -> IDLE after one cycle. Illegal count (0 or >DEPTH): ld_err pulses
//   next cycle, state stays IDLE. ld_start outside IDLE is ignored.
//  IDLE: im_pc=fetch_pc, im_memRead=fetch_req (combinational), fetch_stall=0, im_memWrite=0.
//   ld_start and fetch_req in the same cycle: fetch is served that cycle, burst begins next cycle.
//  LOAD: ld_ready=1, fetch_stall=fetch_req, im_memRead=0. Accept on posedge k when ld_valid&&ld_ready;
//   in cycle k+1 im_memWrite=1 (registered), im_dataIn=accepted word,
//   im_pc={zeros, addr, 2'b00}; IM commits on the negedge inside cycle k+1. Write latency 1 cycle.
//   Back-to-back accepts allowed (one word/cycle). ld_valid=0 cycles: im_memWrite=0, no address advance.
//  Address: addr=ld_base+i mod DEPTH (ADDR_W-bit wrap, e.g. base 14, count 4 -> 14,15,0,1).
//  LAST: commits the final word (im_memWrite=1), ld_ready=0, ld_done=1, busy=1, fetch_stall=fetch_req.
//  IDLE resumes fetch in the cycle after LAST; first fetch reads the freshly written data.
//  busy=1 in LOAD and LAST. im_pc/im_dataIn hold last value when im_memWrite=0 outside IDLE.
// TESTING
//  T1 reset=0 mid-idle, fetch_req=1 pc=0x8 after release -> im_pc=0x8, im_memRead=1, fetch_stall=0.
//  T2 base=0 count=3, data A,B,C back-to-back -> im_memWrite 3 cycles at im_pc 0x0,0x4,0x8;
//   ld_done pulses with C write; fetch pc=0x4 next cycle returns B.
//  T3 base=14 count=4 with ld_valid gaps -> writes to 0x38,0x3C,0x00,0x04 only on valid cycles.
//  T4 ld_start count=0 then count=17 -> ld_err pulse each, state stays IDLE, no im_memWrite.
//  T5 fetch_req=1 throughout a count=2 burst -> fetch_stall=1 in LOAD/LAST, 0 immediately after.
//  T6 reset=0 after 2 of 5 words -> im_memWrite/busy drop at once; words 0,1 kept; new burst accepted.

Source files
------------

// File: rtl/im_load_ctrl_if.sv
// Bus bundle between the CPU fetch path / boot loader (master side) and the
// instruction-memory load controller (slave side). The IM-facing outputs are
// carried here as well so one port connects the controller.
//   fetch_*    : CPU fetch request, stall back to the PC stage
//   ld_*       : loader burst control and word stream
//   busy       : controller is in a load burst
//   im_*       : IM address / write data / write and read enables
interface im_load_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [31:0]       fetch_pc;
    logic              fetch_stall;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic [ADDR_W:0]   ld_count;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              ld_err;
    logic              busy;
    logic [31:0]       im_pc;
    logic [DATA_W-1:0] im_dataIn;
    logic              im_memWrite;
    logic              im_memRead;

    modport master (
        output fetch_req, fetch_pc, ld_start, ld_base, ld_count, ld_valid, ld_data,
        input  fetch_stall, ld_ready, ld_done, ld_err, busy,
               im_pc, im_dataIn, im_memWrite, im_memRead
    );

    modport slave (
        input  fetch_req, fetch_pc, ld_start, ld_base, ld_count, ld_valid, ld_data,
        output fetch_stall, ld_ready, ld_done, ld_err, busy,
               im_pc, im_dataIn, im_memWrite, im_memRead
    );
endinterface

// File: rtl/im_load_ctrl.sv
// Arbitrates the instruction-memory port between CPU fetch and a loader burst.
// IDLE passes fetch straight through; a burst stalls fetch and writes
// ld_count words from ld_base upward, wrapping inside the DEPTH-word IM.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : im_load_ctrl_if.slave (fetch, loader stream, IM control)
module im_load_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    im_load_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LAST} state_t;

    localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q;       // words still to accept
    logic [ADDR_W-1:0] nxt_addr_q;  // address for the next accepted word
    logic [ADDR_W-1:0] wr_addr_q;   // address of the word being committed
    logic [DATA_W-1:0] dat_q;
    logic              wr_q;
    logic              err_q;

    logic cnt_ok, start_ok, accept;

    assign cnt_ok   = (bus.ld_count != '0) && (bus.ld_count <= MAX_CNT);
    assign start_ok = (state_q == S_IDLE) && bus.ld_start && cnt_ok;
    assign accept   = (state_q == S_LOAD) && bus.ld_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_ok) state_d = S_LOAD;
            S_LOAD: if (accept && cnt_q == ONE_C) state_d = S_LAST;
            S_LAST: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write path is registered: a word accepted on edge k is presented to the
    // IM for the whole of cycle k+1 and committed by the IM on that negedge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            nxt_addr_q <= '0;
            wr_addr_q  <= '0;
            dat_q      <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= (state_q == S_IDLE) && bus.ld_start && !cnt_ok;
            wr_q  <= accept;
            if (start_ok) begin
                nxt_addr_q <= bus.ld_base;
                cnt_q      <= bus.ld_count;
            end
            if (accept) begin
                dat_q      <= bus.ld_data;
                wr_addr_q  <= nxt_addr_q;
                nxt_addr_q <= nxt_addr_q + ONE_A;   // natural ADDR_W-bit wrap
                cnt_q      <= cnt_q - ONE_C;
            end
        end
    end

    logic idle;
    assign idle = (state_q == S_IDLE);

    always_comb begin
        bus.busy        = !idle;
        bus.ld_ready    = (state_q == S_LOAD);
        bus.ld_done     = (state_q == S_LAST);
        bus.ld_err      = err_q;
        bus.fetch_stall = !idle && bus.fetch_req;
        bus.im_memRead  = idle && bus.fetch_req;
        bus.im_memWrite = wr_q;
        bus.im_dataIn   = dat_q;
        // Outside IDLE the address holds the last written word when no write.
        bus.im_pc       = idle ? bus.fetch_pc
                               : {{(32-ADDR_W-2){1'b0}}, wr_addr_q, 2'b00};
    end
endmodule

// File: tb/tb_im_load_ctrl.sv
module tb_im_load_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    im_load_ctrl_if #(.ADDR_W(4), .DATA_W(32)) bus();

    im_load_ctrl #(.DEPTH(16), .ADDR_W(4), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t sb_q[$];

    // Behavioural IM: commits on negedge, combinational read.
    logic [31:0] mem [16];
    logic [31:0] im_rdata;
    assign im_rdata = mem[bus.im_pc[5:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.im_memWrite === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", bus.im_pc, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("wr_addr", bus.im_pc, {26'b0, e.addr, 2'b00});
                chk("wr_data", bus.im_dataIn, e.data);
            end
            mem[bus.im_pc[5:2]] = bus.im_dataIn;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_chk(input logic [31:0] pc, input logic [31:0] exp);
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = pc;
        #1;
        chk("fetch_read_en", {31'b0, bus.im_memRead}, 32'd1);
        chk("fetch_data", im_rdata, exp);
    endtask

    // Full burst; gaps[i]=1 inserts one ld_valid=0 cycle before word i.
    task automatic do_load(input logic [3:0] base, input int cnt,
                           input logic [31:0] seed, input logic [15:0] gaps);
        bus.ld_start = 1'b1;
        bus.ld_base  = base;
        bus.ld_count = 5'(cnt);
        tick;
        bus.ld_start = 1'b0;
        chk("load_busy", {31'b0, bus.busy}, 32'd1);
        chk("load_ready", {31'b0, bus.ld_ready}, 32'd1);
        for (int i = 0; i < cnt; i++) begin
            if (gaps[i]) begin
                bus.ld_valid = 1'b0;
                tick;
                chk("gap_no_write", {31'b0, bus.im_memWrite}, 32'd0);
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = seed + 32'(i);
            sb_q.push_back('{addr: 4'((int'(base) + i) % 16), data: seed + 32'(i)});
            tick;
        end
        bus.ld_valid = 1'b0;
        chk("last_done", {31'b0, bus.ld_done}, 32'd1);
        chk("last_write", {31'b0, bus.im_memWrite}, 32'd1);
        chk("last_ready", {31'b0, bus.ld_ready}, 32'd0);
        chk("last_busy", {31'b0, bus.busy}, 32'd1);
        tick;
        chk("post_done", {31'b0, bus.ld_done}, 32'd0);
        chk("post_busy", {31'b0, bus.busy}, 32'd0);
        chk("post_write", {31'b0, bus.im_memWrite}, 32'd0);
    endtask

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        start;
        logic [4:0]  cnt;
        logic        exp_read;
        logic        exp_err;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        vecs[0] = '{1'b1, 32'h0000_0008, 1'b0, 5'd0,  1'b1, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_003C, 1'b0, 5'd0,  1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h1234_5678, 1'b0, 5'd0,  1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0000, 1'b1, 5'd0,  1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0020, 1'b1, 5'd17, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 32'h0000_0004, 1'b1, 5'd31, 1'b0, 1'b1};

        reset = 1'b0;
        bus.fetch_req = 0; bus.fetch_pc = 0; bus.ld_start = 0; bus.ld_base = 0;
        bus.ld_count = 0; bus.ld_valid = 0; bus.ld_data = 0;
        tick; tick;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_ready", {31'b0, bus.ld_ready}, 32'd0);
        chk("rst_write", {31'b0, bus.im_memWrite}, 32'd0);
        chk("rst_done", {31'b0, bus.ld_done}, 32'd0);
        chk("rst_err", {31'b0, bus.ld_err}, 32'd0);
        chk("rst_datain", bus.im_dataIn, 32'd0);
        reset = 1'b1;
        tick;
        // T1: reset pulse mid-idle, then pass-through vectors; T4 rows 3..5.
        reset = 1'b0; #2; reset = 1'b1;
        tick;
        for (int i = 0; i < 6; i++) begin
            bus.fetch_req = vecs[i].req;
            bus.fetch_pc  = vecs[i].pc;
            bus.ld_start  = vecs[i].start;
            bus.ld_count  = vecs[i].cnt;
            #1;
            chk("vec_im_pc", bus.im_pc, vecs[i].pc);
            chk("vec_read", {31'b0, bus.im_memRead}, {31'b0, vecs[i].exp_read});
            chk("vec_stall", {31'b0, bus.fetch_stall}, 32'd0);
            tick;
            chk("vec_err", {31'b0, bus.ld_err}, {31'b0, vecs[i].exp_err});
            chk("vec_busy", {31'b0, bus.busy}, 32'd0);
        end
        bus.ld_start = 1'b0; bus.fetch_req = 1'b0;
        tick;
        chk("err_one_pulse", {31'b0, bus.ld_err}, 32'd0);

        // T2
        do_load(4'd0, 3, 32'h0000_000A, 16'h0000);
        fetch_chk(32'h4, 32'h0000_000B);
        fetch_chk(32'h8, 32'h0000_000C);
        bus.fetch_req = 1'b0;

        // T3: wrap with gaps
        do_load(4'd14, 4, 32'h0000_3000, 16'b1011);
        fetch_chk(32'h38, 32'h0000_3000);
        fetch_chk(32'h3C, 32'h0000_3001);
        fetch_chk(32'h00, 32'h0000_3002);
        fetch_chk(32'h04, 32'h0000_3003);
        fetch_chk(32'h08, 32'h0000_000C);

        // T5: fetch held during burst, start in same cycle as fetch
        bus.fetch_req = 1'b1; bus.fetch_pc = 32'h20;
        bus.ld_start = 1'b1; bus.ld_base = 4'd8; bus.ld_count = 5'd2;
        #1;
        chk("t5_served_read", {31'b0, bus.im_memRead}, 32'd1);
        chk("t5_served_stall", {31'b0, bus.fetch_stall}, 32'd0);
        tick;
        bus.ld_count = 5'd0;   // ld_start stays high in LOAD: must be ignored
        chk("t5_load_stall", {31'b0, bus.fetch_stall}, 32'd1);
        chk("t5_load_read", {31'b0, bus.im_memRead}, 32'd0);
        bus.ld_valid = 1'b1; bus.ld_data = 32'h5000;
        sb_q.push_back('{addr: 4'd8, data: 32'h5000});
        tick;
        chk("t5_ignored_start", {31'b0, bus.ld_err}, 32'd0);
        chk("t5_load_stall2", {31'b0, bus.fetch_stall}, 32'd1);
        bus.ld_start = 1'b0;
        bus.ld_data = 32'h5001;
        sb_q.push_back('{addr: 4'd9, data: 32'h5001});
        tick;
        bus.ld_valid = 1'b0;
        chk("t5_last_stall", {31'b0, bus.fetch_stall}, 32'd1);
        chk("t5_last_done", {31'b0, bus.ld_done}, 32'd1);
        tick;
        chk("t5_idle_stall", {31'b0, bus.fetch_stall}, 32'd0);
        chk("t5_idle_err", {31'b0, bus.ld_err}, 32'd0);
        fetch_chk(32'h20, 32'h5000);
        fetch_chk(32'h24, 32'h5001);
        bus.fetch_req = 1'b0;

        // T6: reset after 2 of 5 words
        bus.ld_start = 1'b1; bus.ld_base = 4'd4; bus.ld_count = 5'd5;
        tick;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 32'h6000;
        sb_q.push_back('{addr: 4'd4, data: 32'h6000});
        tick;
        bus.ld_data = 32'h6001;
        sb_q.push_back('{addr: 4'd5, data: 32'h6001});
        tick;
        @(negedge clk); #1;
        chk("t6_pre_write", {31'b0, bus.im_memWrite}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_rst_write", {31'b0, bus.im_memWrite}, 32'd0);
        chk("t6_rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("t6_rst_ready", {31'b0, bus.ld_ready}, 32'd0);
        bus.ld_valid = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        do_load(4'd10, 1, 32'h0000_7000, 16'h0000);
        fetch_chk(32'h10, 32'h6000);
        fetch_chk(32'h14, 32'h6001);
        fetch_chk(32'h18, 32'hDEAD_0006);
        fetch_chk(32'h28, 32'h7000);
        bus.fetch_req = 1'b0;
        tick;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
